// File: rtl/adc_pkg.sv
// Shared definitions for the ADC window path; the window counter imports the
// same package so both ends agree on the window period.
package adc_pkg;

    localparam int WIN_LEN = 128;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_ACQ  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// N-stage synchronizer for a single asynchronous bit, synchronous active-low reset.
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[N-2:0], d};
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/adc_window_accumulator.sv
// Counts synchronized comparator-high cycles over each roll-delimited window and
// hands each density result to a valid/ready consumer, flagging dropped results.
module adc_window_accumulator
    import adc_pkg::*;
#(
    parameter int WIN_LEN     = adc_pkg::WIN_LEN,
    parameter int CNT_W       = adc_pkg::CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             comp_in,
    input  logic             roll,
    output logic [CNT_W-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun,
    output logic             busy
);

    localparam logic [CNT_W-1:0] WIN_MAX = CNT_W'(WIN_LEN);

    state_t           state;
    state_t           next_state;
    logic             comp_s;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_next;
    logic [CNT_W-1:0] result;
    logic [CNT_W-1:0] data_next;
    logic             valid_next;
    logic             overrun_next;

    sync_ff #(.N(SYNC_STAGES)) u_comp_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (comp_in),
        .q       (comp_s)
    );

    // The roll cycle itself belongs to the window that is closing.
    assign result = acc + {{(CNT_W-1){1'b0}}, comp_s};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            acc          <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= next_state;
            acc          <= acc_next;
            sample_data  <= data_next;
            sample_valid <= valid_next;
            overrun      <= overrun_next;
            busy         <= (next_state == ST_ACQ);
        end
    end

    always_comb begin
        next_state   = state;
        acc_next     = acc;
        data_next    = sample_data;
        valid_next   = sample_valid;
        overrun_next = overrun;

        if (sample_valid && sample_ready) begin
            valid_next = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                acc_next     = '0;
                overrun_next = 1'b0;
                if (enable) begin
                    next_state = ST_ARM;
                end
            end
            ST_ARM: begin
                acc_next = '0;
                if (!enable) begin
                    next_state = ST_IDLE;
                end else if (roll) begin
                    next_state = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (!enable) begin
                    next_state = ST_IDLE;
                    acc_next   = '0;
                end else if (roll) begin
                    acc_next = '0;
                    // A slot is free if empty or being drained in this same cycle.
                    if (!sample_valid || sample_ready) begin
                        data_next  = result;
                        valid_next = 1'b1;
                    end else begin
                        overrun_next = 1'b1;
                    end
                end else begin
                    acc_next = result;
                end
            end
            default: begin
                next_state = ST_IDLE;
                acc_next   = '0;
            end
        endcase
    end

    // A count past the window length means roll is not arriving every WIN_LEN cycles.
    assert property (@(posedge clk) disable iff (!reset_n) acc <= WIN_MAX);

endmodule

// File: tb/tb_adc_window_accumulator.sv
// Scoreboard bench: stimulus queues hand-computed results, a monitor pops them on each transfer.
module tb_adc_window_accumulator;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       comp_in;
    logic       roll;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic       sample_ready;
    logic       overrun;
    logic       busy;

    int unsigned exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          comp_mode = 0;
    logic [6:0]  roll_cnt;

    adc_window_accumulator dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .comp_in      (comp_in),
        .roll         (roll),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running window counter model plus comparator pattern source (0, 1, toggle).
    initial begin
        roll     = 1'b0;
        comp_in  = 1'b0;
        roll_cnt = 7'd0;
        forever begin
            @(negedge clk);
            roll_cnt = roll_cnt + 7'd1;
            roll     = (roll_cnt == 7'd0);
            case (comp_mode)
                0:       comp_in = 1'b0;
                1:       comp_in = 1'b1;
                default: comp_in = ~comp_in;
            endcase
        end
    end

    task automatic check_output(input string name, input int unsigned actual, input int unsigned expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Returns at the tick whose following rising edge is a roll cycle.
    task automatic wait_roll();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!roll && n < 200);
        if (!roll) begin
            checks++;
            errors++;
            $display("[TB] FAIL roll_wait: got no roll expected roll within 200 cycles");
        end
    endtask

    task automatic apply_stimulus(input int mode, input logic en, input logic rdy);
        comp_mode    = mode;
        enable       = en;
        sample_ready = rdy;
    endtask

    // Monitor: every transfer edge must match the oldest expected result.
    initial begin
        int unsigned exp_val;
        forever begin
            @(negedge clk);
            #3;
            if (reset_n && sample_valid && sample_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: got %0d expected no transfer", sample_data);
                end else begin
                    exp_val = exp_q.pop_front();
                    check_output("result", sample_data, exp_val);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got no finish expected finish before 500000 ns");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset_n = 1'b0;
        apply_stimulus(1, 1'b0, 1'b0);
        repeat (3) tick();
        check_output("reset_data", sample_data, 0);
        check_output("reset_valid", sample_valid, 0);
        check_output("reset_overrun", overrun, 0);
        check_output("reset_busy", busy, 0);
        reset_n = 1'b1;

        $display("[TB] full-scale");
        apply_stimulus(1, 1'b1, 1'b1);
        wait_roll();
        for (int w = 0; w < 3; w++) begin
            wait_roll();
            exp_q.push_back(128);
            tick();
            check_output("full_valid_high", sample_valid, 1);
            check_output("full_busy", busy, 1);
            tick();
            check_output("full_valid_pulse", sample_valid, 0);
        end

        $display("[TB] half-scale and zero");
        apply_stimulus(2, 1'b0, 1'b1);
        repeat (4) tick();
        enable = 1'b1;
        wait_roll();
        for (int w = 0; w < 2; w++) begin
            wait_roll();
            exp_q.push_back(64);
            tick();
            check_output("half_valid_high", sample_valid, 1);
        end
        apply_stimulus(0, 1'b0, 1'b1);
        repeat (4) tick();
        enable = 1'b1;
        wait_roll();
        for (int w = 0; w < 2; w++) begin
            wait_roll();
            exp_q.push_back(0);
            tick();
            check_output("zero_valid_high", sample_valid, 1);
            tick();
            check_output("zero_valid_pulse", sample_valid, 0);
        end

        $display("[TB] backpressure");
        apply_stimulus(1, 1'b0, 1'b0);
        repeat (4) tick();
        enable = 1'b1;
        wait_roll();
        wait_roll();
        exp_q.push_back(128);
        tick();
        check_output("bp_valid", sample_valid, 1);
        check_output("bp_overrun_before", overrun, 0);
        wait_roll();
        tick();
        check_output("bp_overrun_after", overrun, 1);
        check_output("bp_data_held", sample_data, 128);
        check_output("bp_valid_held", sample_valid, 1);
        sample_ready = 1'b1;
        tick();
        check_output("bp_drained", sample_valid, 0);

        $display("[TB] simultaneous accept and load");
        apply_stimulus(1, 1'b0, 1'b0);
        repeat (2) tick();
        check_output("idle_overrun_clear", overrun, 0);
        check_output("idle_busy", busy, 0);
        enable = 1'b1;
        wait_roll();
        wait_roll();
        exp_q.push_back(128);
        wait_roll();
        sample_ready = 1'b1;
        exp_q.push_back(128);
        tick();
        check_output("sim_valid", sample_valid, 1);
        check_output("sim_overrun", overrun, 0);
        tick();
        check_output("sim_drained", sample_valid, 0);

        $display("[TB] enable drop");
        sample_ready = 1'b0;
        wait_roll();
        exp_q.push_back(128);
        wait_roll();
        tick();
        check_output("drop_overrun_set", overrun, 1);
        repeat (59) tick();
        enable = 1'b0;
        tick();
        check_output("drop_busy", busy, 0);
        tick();
        check_output("drop_overrun_clear", overrun, 0);
        check_output("drop_valid_kept", sample_valid, 1);
        check_output("drop_data_kept", sample_data, 128);
        sample_ready = 1'b1;
        tick();
        check_output("drop_drained", sample_valid, 0);
        wait_roll();
        tick();
        check_output("drop_no_result", sample_valid, 0);
        enable = 1'b1;
        wait_roll();
        check_output("rearm_no_early", sample_valid, 0);
        wait_roll();
        check_output("rearm_still_empty", sample_valid, 0);
        exp_q.push_back(128);
        tick();
        check_output("rearm_valid", sample_valid, 1);
        tick();

        $display("[TB] reset mid-window");
        sample_ready = 1'b0;
        wait_roll();
        wait_roll();
        tick();
        check_output("rst_pre_overrun", overrun, 1);
        repeat (126) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_output("rst_data", sample_data, 0);
        check_output("rst_valid", sample_valid, 0);
        check_output("rst_overrun", overrun, 0);
        check_output("rst_busy", busy, 0);
        tick();
        check_output("rst_roll_ignored", busy, 0);
        wait_roll();
        tick();
        check_output("rst_rearm_busy", busy, 1);
        sample_ready = 1'b1;
        wait_roll();
        exp_q.push_back(128);
        repeat (3) tick();
        check_output("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_window_accumulator.md
Name: adc_window_accumulator

Overview:
- Consumes the 1-cycle `roll` strobe from the 7-bit window counter (high once every 128 clk cycles).
- Counts comparator-high cycles over each 128-cycle window, giving a density (sigma-delta style) conversion result.
- Presents each result on a valid/ready output port for the downstream readout/register stage.

Parameters:
- WIN_LEN, 128, cycles per window; must equal the upstream counter period.
- CNT_W, 8, result width; must hold 0..WIN_LEN inclusive.
- SYNC_STAGES, 2, flops in the comp_in synchronizer; minimum 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  conversion enable, level-sensitive.
- comp_in  in  1  asynchronous analog comparator output.
- roll  in  1  window-end strobe from the window counter; high for 1 cycle per WIN_LEN cycles.
- sample_data  out  CNT_W  conversion result; count of synchronized comparator-high cycles.
- sample_valid  out  1  sample_data holds an unconsumed result.
- sample_ready  in  1  consumer accepts sample_data this cycle.
- overrun  out  1  sticky: at least one result was dropped due to backpressure.
- busy  out  1  high while in the ACQ state.

Behaviour:
- Reset: reset_n is synchronous and active-low; the clock is clk. While reset_n=0 at a rising edge:
  - state=IDLE, acc=0, sync flops=0.
  - sample_data=0, sample_valid=0, overrun=0, busy=0.
  - Reset mid-window discards the partial acc.
- comp_s is comp_in after the SYNC_STAGES flops. All counting uses comp_s, so comp_in reaches the count with SYNC_STAGES cycles of latency.
- States: IDLE, ARM, ACQ. busy = (state==ACQ), registered with the state.
- IDLE:
  - acc held at 0.
  - enable=1 -> ARM.
  - A roll in the same cycle is ignored.
- ARM:
  - Waits for window alignment; any partial window is discarded.
  - roll=1 -> ACQ with acc=0.
  - enable=0 -> IDLE, which takes priority over roll.
- ACQ, cycles with roll=0: acc <= acc + comp_s.
- ACQ, cycle with roll=1:
  - result = acc + comp_s, so the roll cycle is included.
  - acc <= 0; stay in ACQ.
  - Each window is exactly WIN_LEN cycles, so the result lies in 0..128.
- ACQ, enable=0 -> IDLE:
  - acc cleared; the partial window is discarded with no result produced.
  - enable=0 takes priority over a coincident roll.
- Result handoff, on the roll cycle in ACQ:
  - If sample_valid=0, or (sample_valid=1 and sample_ready=1) in that cycle: load sample_data<=result and sample_valid<=1. Accept and reload happen in the same cycle, so this is not an overrun.
  - Otherwise: keep the old sample_data and sample_valid=1, drop the new result, and set overrun<=1.
- Consumer handshake:
  - A transfer occurs on any clock edge with sample_valid=1 and sample_ready=1.
  - With no new load in that cycle, sample_valid<=0.
  - sample_data stays stable while sample_valid=1 and is not transferred.
  - sample_ready with sample_valid=0 has no effect.
- overrun:
  - Sticky.
  - Cleared only by reset or by the cycle in which state==IDLE.
- Leaving ACQ does not drop a pending output: sample_valid and sample_data remain until consumed.
- Latency: sample_valid rises 1 cycle after the roll cycle. Registered output only; no combinational path from input to output.
- Width: acc is CNT_W bits and never exceeds WIN_LEN, so no saturation logic is needed. An assertion must flag acc>WIN_LEN, which indicates a roll period mismatch.

Decomposition:
- Shared package adc_pkg:
  - state enum/localparams ST_IDLE=2'd0, ST_ARM=2'd1, ST_ACQ=2'd2.
  - WIN_LEN=128.
  - CNT_W=8.
  - Shared with the window counter so both ends agree on the period.
- One sub-module: sync_ff (parameterised N-stage synchronizer with synchronous active-low reset), used for comp_in.

Test Plan:
- Full-scale: reset, enable=1, comp_in=1 constant, sample_ready=1. After the ARM roll, each roll is followed next cycle by sample_data=128 with sample_valid pulsing for 1 cycle; busy=1.
- Half-scale: comp_in toggles every cycle (50%). Every result is 64; comp_in=0 constant gives 0 and sample_valid still pulses.
- Backpressure/overrun: comp_in=1, sample_ready=0 for 300 cycles. The first result (128) is held stable and overrun=1 after the second roll. Raising sample_ready gives one transfer with data=128, then sample_valid=0.
- Simultaneous accept and load: sample_valid=1 pending with sample_ready=1 exactly on the roll cycle. The new result loads, sample_valid stays 1, and overrun stays 0.
- Enable drop: enable=0 at cycle 60 of an ACQ window with a result pending. State goes IDLE with busy=0, no new result, the pending result still transfers, and overrun clears. Re-enable gives the first result only after ARM plus one full window.
- Reset mid-window: reset_n=0 for 1 cycle during ACQ. All outputs return to 0 and state is IDLE; a roll in the following cycle is ignored.
